// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding and digit-range constants for the digit scan controller.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        PAUSE,
        DONE
    } scan_state_t;

    localparam int         NUM_DIGITS = 6;
    localparam logic [2:0] SEL_FIRST  = 3'd1;
    localparam logic [2:0] SEL_LAST   = 3'(NUM_DIGITS);

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: per-digit dwell counter with clear, enable and terminal count.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : synchronous clear (wins over en)
//   en           : advance the count; wraps to 0 after DWELL_CYCLES-1
//   cnt_q        : current count, never above DWELL_CYCLES-1
//   tc           : count is at DWELL_CYCLES-1
//   blank        : next count lies in the blanked head of the dwell
//                  (only with SCAN_BLANK_EN defined, otherwise tied 0)
module dwell_timer #(
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic                            en,
    output logic [$clog2(DWELL_CYCLES)-1:0] cnt_q,
    output logic                            tc,
    output logic                            blank
);

    localparam int W = $clog2(DWELL_CYCLES);

    logic [W-1:0] cnt_d;

    assign tc = (cnt_q == W'(DWELL_CYCLES - 1));

    always_comb begin
        cnt_d = clr ? '0 : (en ? (tc ? '0 : cnt_q + W'(1)) : cnt_q);
    end

    // Blanking looks at the next count so the registered enable lines up with the count.
`ifdef SCAN_BLANK_EN
    assign blank = (cnt_d < W'(DWELL_CYCLES / 4));
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: steps an LED display selector over digits 1..6 with a dwell per digit, or follows sw_in manually.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a scan (honoured only in IDLE, and not together with stop)
//   stop       : abort the scan back to manual mode
//   pause      : level; freezes the scan while high
//   sw_in      : manual selector used in IDLE
//   sel        : registered display selector
//   sw_led_ena : registered display enable (blanked at the head of each dwell with SCAN_BLANK_EN)
//   busy       : high in SCAN, PAUSE and DONE
//   done       : one-cycle pulse at the end of a full pass
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int REPEAT_SCAN  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [2:0] sw_in,
    output logic [2:0] sel,
    output logic       sw_led_ena,
    output logic       busy,
    output logic       done
);

    scan_state_t state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic        ena_q, ena_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        running, running_d, cnt_en, cnt_clr, tc, blank, advance;
    logic [$clog2(DWELL_CYCLES)-1:0] cnt_q;

    assign running   = (state_q == SCAN) || (state_q == PAUSE);
    assign running_d = (state_d == SCAN) || (state_d == PAUSE);
    // PAUSE with pause low counts like SCAN, so the dwell resumes on the very release cycle.
    assign cnt_en    = running && !stop && !pause;
    assign cnt_clr   = !(running && running_d);
    assign advance   = cnt_en && tc;

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt_q (cnt_q),
        .tc    (tc),
        .blank (blank)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ena_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ena_q   <= ena_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        state_d = (start && !stop) ? SCAN : IDLE;
            SCAN, PAUSE: state_d = stop ? IDLE : pause ? PAUSE : (tc && sel_q == SEL_LAST) ? DONE : SCAN;
            DONE:        state_d = (stop || REPEAT_SCAN == 0) ? IDLE : SCAN;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d  = (state_d == IDLE) ? sw_in :
                 (state_d == DONE) ? SEL_LAST :
                 !running          ? SEL_FIRST :
                 advance           ? sel_q + 3'd1 : sel_q;
        ena_d  = running_d ? !blank : 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign sel        = sel_q;
    assign sw_led_ena = ena_q;
    assign busy       = busy_q;
    assign done       = done_q;

    logic unused_cnt;
    assign unused_cnt = ^cnt_q;

endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL_CYCLES, default 100_000_000, meaning clock cycles each digit is shown during a scan (minimum 4).
REQ-002 The block SHALL have parameter REPEAT_SCAN, default 0, meaning 1 = restart the scan after DONE, 0 = return to IDLE.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle request to begin an automatic scan.
REQ-006 The block SHALL have port stop, input, 1 bit: abort the scan and return to manual mode.
REQ-007 The block SHALL have port pause, input, 1 bit: level input; freezes the scan while high.
REQ-008 The block SHALL have port sw_in, input, 3 bits: user switch selector for manual mode.
REQ-009 The block SHALL have port sel, output, 3 bits: registered selector driven to the LED display mux.
REQ-010 The block SHALL have port sw_led_ena, output, 1 bit: registered display enable driven to the LED display mux.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in SCAN, PAUSE or DONE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when a full pass over digits 1..6 completes.

Function
REQ-013 States SHALL be IDLE, SCAN, PAUSE and DONE; all outputs SHALL be registered.
REQ-014 In IDLE, sel SHALL load sw_in every cycle (1-cycle latency) and sw_led_ena SHALL be 1.
REQ-015 start in IDLE SHALL move the block to SCAN next cycle with sel=1, dwell counter=0 and busy=1; start outside IDLE SHALL be ignored.
REQ-016 In SCAN, the dwell counter SHALL increment each cycle; at DWELL_CYCLES-1 it SHALL clear and sel SHALL increment, or, if sel=6, the block SHALL enter DONE.
REQ-017 sel SHALL stay within 1..6 in SCAN, PAUSE and DONE; values 0 and 7 SHALL appear only in IDLE.
REQ-018 pause high in SCAN SHALL move the block to PAUSE, holding the counter, sel and sw_led_ena; pause low SHALL return it to SCAN and resume from the held count.
REQ-019 DONE SHALL last exactly one cycle with done=1 and sel=6; the next state SHALL be SCAN (sel=1, counter=0) if REPEAT_SCAN=1, otherwise IDLE.
REQ-020 stop in SCAN, PAUSE or DONE SHALL force IDLE next cycle with busy=0 and no done pulse.
REQ-021 Priority SHALL be stop > pause > dwell terminal count; start and stop in the same cycle in IDLE SHALL keep the block in IDLE.
REQ-022 Counter width SHALL be $clog2(DWELL_CYCLES); the counter SHALL never exceed DWELL_CYCLES-1.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, sel=0, sw_led_ena=0, busy=0, done=0 and counter=0, including mid-scan.
REQ-024 On the first clock after reset release, IDLE behaviour (REQ-014) SHALL apply.

Configuration
REQ-025 With macro SCAN_BLANK_EN defined, sw_led_ena SHALL be 0 for the first DWELL_CYCLES/4 cycles of every digit's dwell in SCAN and PAUSE, and 1 for the rest; without it, sw_led_ena SHALL be 1 throughout SCAN, PAUSE and DONE.

Structure
REQ-026 Package scan_pkg SHALL hold the state enum typedef scan_state_t and constants NUM_DIGITS=6, SEL_FIRST=3'd1 and SEL_LAST=3'd6.
REQ-027 Sub-module dwell_timer SHALL implement the counter with clear, enable and terminal-count output, parameterised by DWELL_CYCLES.

Verification (DWELL_CYCLES=4)
REQ-028 Reset, then sw_in=5 with no start: sel=5 and sw_led_ena=1 one cycle later; sw_in=0 gives sel=0.
REQ-029 Pulse start: sel steps 1,2,3,4,5,6 with 4 cycles each; done=1 for one cycle 24 cycles after entering SCAN; then IDLE with busy=0.
REQ-030 Hold pause high for 10 cycles during sel=3 at count 2: sel stays 3 and the count stays 2; after release, sel=4 two cycles later.
REQ-031 Assert stop during sel=4: next cycle IDLE, sel=sw_in, busy=0, no done pulse. Assert start and stop together in IDLE: the block stays IDLE.
REQ-032 Drop rst_n asynchronously mid-scan: outputs zero without a clock edge. With REPEAT_SCAN=1: after done, sel=1 next cycle.
REQ-033 With SCAN_BLANK_EN defined: sw_led_ena=0 for the first cycle of each 4-cycle dwell and 1 for the other three.
